// File: rtl/apb_cfg_master_if.sv
// Command/response and APB bus bundle for apb_cfg_master.
//
// Handshake rules: a command transfers on a rising PCLK edge where
// cmd_valid && cmd_ready. cmd_ready depends only on the master's state,
// never on cmd_valid. rsp_valid is a one-cycle pulse with no back-pressure;
// rsp_rdata/rsp_err stay valid until the next pulse. On the APB side the
// master drives PSEL/PENABLE/PADDR/PWRITE/PWDATA, and the slave drives
// PREADY/PRDATA, which are only looked at while PSEL && PENABLE.
interface apb_cfg_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [7:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_cfg_master.sv
// APB configuration master: turns single local read/write commands into
// APB transfers to three config registers (0x10, 0x14, 0x1C), filters
// illegal addresses locally and aborts transfers whose slave never answers.
module apb_cfg_master #(
  parameter int unsigned TIMEOUT = 15  // max ACCESS cycles with PREADY=0, 1..255
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  apb_cfg_master_if.master     bus,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  // Counter value on the last permitted ACCESS cycle before abort.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] paddr_q, paddr_d;
  logic [7:0] pwdata_q, pwdata_d;
  logic       pwrite_q, pwrite_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_rdata_q, rsp_rdata_d;
  logic       rsp_err_q, rsp_err_d;

  logic       addr_legal;
  logic [7:0] wdata_mask;

  // Address decode: which registers exist and how many bits each implements.
  always_comb begin
    addr_legal = 1'b1;
    wdata_mask = 8'h00;
    case (bus.cmd_addr)
      8'h10:   wdata_mask = 8'h01;
      8'h14:   wdata_mask = 8'h0F;
      8'h1C:   wdata_mask = 8'h07;
      default: addr_legal = 1'b0;
    endcase
  end

  // Next-state, bus-register and response computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          if (addr_legal) begin
            state_d  = ST_SETUP;
            cnt_d    = 8'd0;
            paddr_d  = bus.cmd_addr;
            pwrite_d = bus.cmd_write;
            // Unimplemented bits go out as zero; reads carry no data.
            pwdata_d = bus.cmd_write ? (bus.cmd_wdata & wdata_mask) : 8'h00;
          end else begin
            // Rejected locally: the bus is left untouched.
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 8'h00;
          end
        end
      end

      ST_SETUP: begin
        state_d = ST_ACCESS;
      end

      ST_ACCESS: begin
        // A ready slave wins over the timeout on the same edge.
        if (bus.PREADY) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = pwrite_q ? 8'h00 : bus.PRDATA;
        end else if (cnt_q == LAST_WAIT) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 8'h00;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset forces the bus idle immediately.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      paddr_q     <= 8'h00;
      pwdata_q    <= 8'h00;
      pwrite_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // PSEL/PENABLE and cmd_ready decode straight from the state register.
  assign bus.PSEL      = (state_q != ST_IDLE);
  assign bus.PENABLE   = (state_q == ST_ACCESS);
  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign dbg_state     = state_q;

endmodule

// File: doc/apb_cfg_master.md
APB_CFG_MASTER -- requirements
Module: apb_cfg_master

Interface
REQ-001 Parameter TIMEOUT, default 15, meaning max ACCESS cycles with PREADY=0 before abort; legal range 1..255.
REQ-002 PCLK  input  1  APB clock; all logic on rising edge.
REQ-003 PRESETn  input  1  reset, asynchronous assert, active-low, synchronous deassert at the source.
REQ-004 cmd_valid  input  1  command request from local host.
REQ-005 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a PCLK edge.
REQ-006 cmd_write  input  1  1=write, 0=read.
REQ-007 cmd_addr  input  8  target register address.
REQ-008 cmd_wdata  input  8  write data.
REQ-009 rsp_valid  output  1  one-cycle completion pulse.
REQ-010 rsp_rdata  output  8  read data; valid with rsp_valid.
REQ-011 rsp_err  output  1  1=illegal address or timeout; valid with rsp_valid.
REQ-012 PSEL, PENABLE, PWRITE  output  1 each  APB control.
REQ-013 PADDR, PWDATA  output  8 each  APB address and write data.
REQ-014 PRDATA  input  8  APB read data; PREADY  input  1  APB transfer complete.

Function
REQ-015 FSM states IDLE, SETUP, ACCESS; encodings PSEL/PENABLE = 0/0, 1/0, 1/1.
REQ-016 cmd_ready SHALL be 1 in IDLE only, combinational on state.
REQ-017 Legal addresses SHALL be 0x10, 0x14, 0x1C; any other accepted address SHALL produce rsp_valid=1, rsp_err=1, rsp_rdata=0 next cycle, no bus activity, FSM stays IDLE.
REQ-018 Legal accepted command: IDLE->SETUP; PADDR, PWRITE loaded from cmd; PWDATA loaded masked: 0x10 keeps [0], 0x14 keeps [3:0], 0x1C keeps [2:0], other bits 0; read loads PWDATA=0.
REQ-019 SETUP->ACCESS unconditionally after one cycle.
REQ-020 ACCESS with PREADY=1 sampled: ->IDLE; next cycle rsp_valid=1, rsp_err=0, rsp_rdata=PRDATA if read else 0.
REQ-021 ACCESS with PREADY=0: wait counter increments; when counter reaches TIMEOUT with PREADY still 0 -> IDLE, next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0; counter cleared on entry to SETUP.
REQ-022 PREADY=1 on the same edge the counter would hit TIMEOUT SHALL complete normally (no error).
REQ-023 Zero-wait latency: accept edge N, SETUP cycle N+1, ACCESS cycle N+2, rsp_valid cycle N+3.
REQ-024 PSEL SHALL deassert for at least one cycle between transfers; new command may be accepted in the rsp_valid cycle.
REQ-025 PADDR, PWRITE, PWDATA SHALL be stable from SETUP through last ACCESS cycle and hold last values in IDLE.
REQ-026 PREADY and PRDATA SHALL be ignored outside ACCESS.
REQ-027 rsp_valid SHALL be a single-cycle pulse; rsp_rdata/rsp_err hold until next rsp_valid.

Reset
REQ-028 PRESETn=0 SHALL immediately force state=IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0x00, PWDATA=0x00, rsp_valid=0, rsp_rdata=0x00, rsp_err=0, counter=0.
REQ-029 Reset during SETUP or ACCESS SHALL abort with no rsp_valid after reset release.
REQ-030 First command SHALL be accepted on the first PCLK edge with PRESETn=1.

Verification
REQ-031 Write 0x14 data 0xAB, PREADY=1 -> SETUP PADDR=0x14 PWDATA=0x0B PWRITE=1, ACCESS next, rsp_valid=1 err=0 three cycles after accept.
REQ-032 Read 0x1C, PREADY low 3 ACCESS cycles, PRDATA=0x04 -> PSEL/PENABLE held 1/1 four cycles, rsp_rdata=0x04 err=0.
REQ-033 Read 0x18 -> rsp_valid=1 err=1 rdata=0x00 next cycle, PSEL never asserted.
REQ-034 TIMEOUT=15, PREADY stuck 0 -> abort after 15 ACCESS cycles, rsp_err=1, PSEL=0 next cycle.
REQ-035 PRESETn pulled low mid-ACCESS -> PSEL/PENABLE 0 without clock edge, no rsp_valid.
REQ-036 Back-to-back write 0x10 then read 0x10, cmd_valid held -> exactly one PSEL=0 cycle between transfers, all bus-stability rules hold.
